uart_rx_frame_ctrl: RTL and testbench

Frame controller for the UART receiver. It detects the start bit on RX_IN and drives the oversampling tick counter (edge_count) and the sample enable (data_sample_en) for the data sampling stage. It consumes that stage's majority-voted sampled_bit, deserializes 8 data bits LSB first, checks optional parity and the stop bit, and presents each good byte with a one-cycle valid strobe.

---
 rtl/uart_rx_frame_ctrl_if.sv | 25 ++
 rtl/uart_rx_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
// Sampler handshake and received-byte bus of the UART receive frame controller.
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sampled_bit;
    logic                  data_sample_en;
    logic [4:0]            edge_count;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;

    modport master (
        input  sampled_bit,
        output data_sample_en, edge_count, P_DATA, data_valid,
               par_err, stp_err, strt_glitch
    );

    modport slave (
        output sampled_bit,
        input  data_sample_en, edge_count, P_DATA, data_valid,
               par_err, stp_err, strt_glitch
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, oversampling tick counter,
// LSB-first deserialisation, optional parity and stop-bit checking.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level with a legal prescale
// START  | start bit; rejected as a glitch if it votes high
// DATA   | shifting in DATA_WIDTH bits, one per last tick
// PARITY | parity bit check (only when parity was enabled at frame start)
// STOP   | stop bit check and byte hand-off
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX_IN,
    input  logic [5:0]           Prescale,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    uart_rx_frame_ctrl_if.master bus
);
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [4:0]            edge_count_q;
    logic [5:0]            presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [BCW-1:0]        bit_count_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  strt_glitch_q;

    logic prescale_legal;
    logic last_tick;
    logic last_bit;
    logic frame_start;
    logic sample_en;
    logic glitch_set;
    logic shift_en;
    logic par_chk;
    logic stop_chk;

    assign prescale_legal = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);
    assign last_tick      = ({1'b0, edge_count_q} == (presc_q - 6'd1));
    assign last_bit       = (bit_count_q == BCW'(DATA_WIDTH - 1));
    assign frame_start    = (state_q == IDLE) && !RX_IN && prescale_legal;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state decode; every non-idle state advances only on its last tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = START;
            START:   if (last_tick)   state_d = sampled_start_ok() ? DATA : IDLE;
            DATA:    if (last_tick && last_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (last_tick)   state_d = STOP;
            STOP:    if (last_tick)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    function automatic logic sampled_start_ok();
        return !bus.sampled_bit;
    endfunction

    // Output/strobe decode derived from the current state.
    always_comb begin
        sample_en  = (state_q != IDLE);
        glitch_set = (state_q == START)  && last_tick && bus.sampled_bit;
        shift_en   = (state_q == DATA)   && last_tick;
        par_chk    = (state_q == PARITY) && last_tick;
        stop_chk   = (state_q == STOP)   && last_tick;
    end

    // Tick counter: held at zero while idle, wraps at the latched prescale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    edge_count_q <= 5'd0;
        else if (state_q == IDLE)    edge_count_q <= 5'd0;
        else if (last_tick)          edge_count_q <= 5'd0;
        else                         edge_count_q <= edge_count_q + 5'd1;
    end

    // Frame configuration is frozen for the whole frame at its start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= 6'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (frame_start) begin
            presc_q   <= Prescale;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    // Deserialiser: data arrives LSB first, so shift right from the MSB end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_count_q <= '0;
            shift_q     <= '0;
        end else if ((state_q == START) && last_tick) begin
            bit_count_q <= '0;
        end else if (shift_en) begin
            bit_count_q <= bit_count_q + 1'b1;
            shift_q     <= {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
        end
    end

    // Error flags: cleared at frame start, then sticky until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else if (frame_start) begin
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            if (par_chk)  par_err_q <= bus.sampled_bit ^ (^shift_q ^ par_typ_q);
            if (stop_chk) stp_err_q <= ~bus.sampled_bit;
        end
    end

    // Byte hand-off and single-cycle strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            strt_glitch_q <= 1'b0;
        end else begin
            data_valid_q  <= 1'b0;
            strt_glitch_q <= glitch_set;
            if (stop_chk && bus.sampled_bit && !par_err_q) begin
                p_data_q     <= shift_q;
                data_valid_q <= 1'b1;
            end
        end
    end

    // Drive the bus from the internal registers.
    always_comb begin
        bus.data_sample_en = sample_en;
        bus.edge_count     = edge_count_q;
        bus.P_DATA         = p_data_q;
        bus.data_valid     = data_valid_q;
        bus.par_err        = par_err_q;
        bus.stp_err        = stp_err_q;
        bus.strt_glitch    = strt_glitch_q;
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: serial frames are generated on RX_IN, a
// one-cycle delayed copy of the line stands in for the sampler vote, and the
// frame-level outcome of each frame is queued and checked when the frame ends.
module tb_uart_rx_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en  = 1'b0;
    logic       par_typ = 1'b0;
    int         cyc = 0;

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8)) bus_if ();

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .RX_IN    (rx),
        .Prescale (prescale),
        .PAR_EN   (par_en),
        .PAR_TYP  (par_typ),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sampler stand-in: its registered vote for a bit is the line value one cycle back.
    initial bus_if.sampled_bit = 1'b1;
    always @(posedge clk) bus_if.sampled_bit <= rx;

    typedef struct {
        int         end_cyc;
        bit         valid;
        bit         glitch;
        bit         perr;
        bit         serr;
        logic [7:0] pdata;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    logic [7:0] pdata_model = 8'h00;
    bit         prev_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: a frame ends when the sample enable drops; any strobe elsewhere is stray.
    always @(negedge clk) begin
        if (!rst) begin
            prev_en = 1'b0;
        end else begin
            if (prev_en && !bus_if.data_sample_en) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame_end", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("end_cycle",   cyc,                    e.end_cyc);
                    chk("data_valid",  int'(bus_if.data_valid),  int'(e.valid));
                    chk("strt_glitch", int'(bus_if.strt_glitch), int'(e.glitch));
                    chk("par_err",     int'(bus_if.par_err),     int'(e.perr));
                    chk("stp_err",     int'(bus_if.stp_err),     int'(e.serr));
                    chk("p_data",      int'(bus_if.P_DATA),      int'(e.pdata));
                end
            end else if (bus_if.data_valid || bus_if.strt_glitch) begin
                chk("stray_strobe", 1, 0);
            end
            prev_en = bus_if.data_sample_en;
        end
    end

    // One frame; called #1 after a clock edge. abort_bit >= 0 asserts reset mid data bit.
    task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                              input bit pbit, input bit stop_bit, input int idle,
                              input int abort_bit);
        exp_t e;
        int   n;
        int   e0;
        n = pe ? 11 : 10;
        prescale = 6'(p);
        par_en   = pe;
        par_typ  = pt;
        rx       = 1'b0;
        e0       = cyc + 1;
        if (abort_bit < 0) begin
            e.end_cyc = e0 + n * p;
            e.glitch  = 1'b0;
            e.perr    = pe && ((($countones(d) + int'(pbit)) % 2) != int'(pt));
            e.serr    = !stop_bit;
            e.valid   = !e.perr && !e.serr;
            if (e.valid) pdata_model = d;
            e.pdata   = pdata_model;
            sb_q.push_back(e);
        end
        hold(1);
        chk("err_cleared_at_start", int'(bus_if.par_err | bus_if.stp_err), 0);
        hold(p - 1);
        prescale = 6'($urandom_range(0, 63));
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == abort_bit) begin
                hold(p / 2);
                rst = 1'b0;
                #1;
                chk("rst_sample_en",  int'(bus_if.data_sample_en), 0);
                chk("rst_edge_count", int'(bus_if.edge_count),     0);
                chk("rst_p_data",     int'(bus_if.P_DATA),         0);
                chk("rst_valid_errs", int'({bus_if.data_valid, bus_if.par_err,
                                            bus_if.stp_err, bus_if.strt_glitch}), 0);
                pdata_model = 8'h00;
                hold(1);
                rst = 1'b1;
                rx  = 1'b1;
                hold(2);
                return;
            end
            hold(p);
        end
        if (pe) begin
            rx = pbit;
            hold(p);
        end
        rx = stop_bit;
        hold(p);
        rx = 1'b1;
        hold(idle);
    endtask

    // False start: line low for fewer cycles than one bit period.
    task automatic send_glitch(input int p, input int low);
        exp_t e;
        prescale  = 6'(p);
        rx        = 1'b0;
        e.end_cyc = cyc + 1 + p;
        e.valid   = 1'b0;
        e.glitch  = 1'b1;
        e.perr    = 1'b0;
        e.serr    = 1'b0;
        e.pdata   = pdata_model;
        sb_q.push_back(e);
        hold(low);
        rx = 1'b1;
        hold(p + 2);
    endtask

    function automatic bit good_parity(input logic [7:0] d, input bit pt);
        return bit'(($countones(d) % 2) != 0) ^ pt;
    endfunction

    initial begin
        int presc_tab[3] = '{8, 16, 32};
        hold(3);
        chk("reset_sample_en",  int'(bus_if.data_sample_en), 0);
        chk("reset_edge_count", int'(bus_if.edge_count),     0);
        chk("reset_p_data",     int'(bus_if.P_DATA),         0);
        chk("reset_flags",      int'({bus_if.data_valid, bus_if.par_err,
                                      bus_if.stp_err, bus_if.strt_glitch}), 0);
        rst = 1'b1;
        hold(3);

        send_frame(8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2, -1);
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 2, -1);
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 2, -1);
        send_glitch(16, 2);
        send_frame(8,  1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 2, -1);
        send_frame(8,  1'b0, 1'b0, 8'h42, 1'b0, 1'b1, 2, -1);
        send_frame(32, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1, -1);
        send_frame(32, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 3, -1);

        // Illegal prescale: a low line must be ignored.
        prescale = 6'd10;
        rx = 1'b0;
        hold(20);
        chk("illegal_presc_idle", int'(bus_if.data_sample_en), 0);
        rx = 1'b1;
        hold(2);

        send_frame(8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 2, 4);
        send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 2, -1);

        for (int k = 0; k < 24; k++) begin
            int         p;
            bit         pe;
            bit         pt;
            logic [7:0] d;
            p  = presc_tab[$urandom_range(0, 2)];
            pe = 1'($urandom);
            pt = 1'($urandom);
            d  = 8'($urandom);
            if ($urandom_range(0, 5) == 0)
                send_glitch(p, $urandom_range(1, p - 1));
            else
                send_frame(p, pe, pt, d,
                           good_parity(d, pt) ^ ($urandom_range(0, 4) == 0),
                           $urandom_range(0, 5) != 0, $urandom_range(1, 3), -1);
        end

        hold(40);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
